// File: rtl/vx_pipe_elastic.sv
// Elastic DEPTH-stage pipeline register: per-stage valid/ready with bubble
// collapsing, synchronous flush, active-low synchronous reset and occupancy count.
module vx_pipe_elastic #(
  parameter int DATAW  = 1,
  parameter int RESETW = 0,
  parameter int DEPTH  = 1,
  parameter int CNTW   = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out,
  output logic [CNTW-1:0]  count,
  output logic             empty,
  output logic             full
);

  if (DEPTH == 0) begin : g_pass
    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign ready_in  = ready_out;
    assign count     = '0;
    assign empty     = 1'b1;
    assign full      = 1'b1;

    logic unused;
    assign unused = &{1'b0, clk, reset, flush};
  end else begin : g_pipe
    // Bits that survive reset; the top RESETW bits are cleared.
    localparam logic [DATAW-1:0] KEEP_MASK = {DATAW{1'b1}} >> RESETW;

    logic [DEPTH-1:0] vq;
    logic [DATAW-1:0] dq [DEPTH];
    logic [DEPTH-1:0] pv;
    logic [DATAW-1:0] pd [DEPTH];
    logic [DEPTH:0]   ld;
    logic [CNTW-1:0]  cnt;

    // A stage may load when it is empty or its successor is loading too.
    always_comb begin
      ld        = '0;
      ld[DEPTH] = ready_out;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        ld[i] = !vq[i] || ld[i+1];
      end
    end

    assign ready_in = ld[0] && !flush && reset;

    always_comb begin
      pv    = '0;
      pv[0] = valid_in && ready_in;
      pd[0] = data_in;
      for (int i = 1; i < DEPTH; i++) begin
        pv[i] = vq[i-1];
        pd[i] = dq[i-1];
      end
    end

    // Stage boundary: valid bits
    always_ff @(posedge clk) begin
      if (!reset) begin
        vq <= '0;
      end else if (flush) begin
        vq <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ld[i]) vq[i] <= pv[i];
        end
      end
    end

    // Stage boundary: payload, written only from a valid predecessor
    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!reset) begin
          dq[i] <= dq[i] & KEEP_MASK;
        end else if (!flush && ld[i] && pv[i]) begin
          dq[i] <= pd[i];
        end
      end
    end

    always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt = cnt + CNTW'(vq[i]);
      end
    end

    assign count     = cnt;
    assign empty     = (cnt == '0);
    assign full      = (cnt == CNTW'(DEPTH));
    assign valid_out = vq[DEPTH-1];
    assign data_out  = dq[DEPTH-1];
  end

endmodule

// File: tb/tb_vx_pipe_elastic.sv
// Scoreboard bench for vx_pipe_elastic: a DEPTH=3 instance with directed
// vectors plus a DEPTH=0 passthrough instance.
module tb_vx_pipe_elastic;

  logic       clk = 1'b0;
  logic       reset, flush, valid_in, ready_out;
  logic [7:0] data_in;
  logic       ready_in, valid_out, empty, full;
  logic [7:0] data_out;
  logic [1:0] count;

  logic       z_valid_in, z_ready_out, z_flush;
  logic [7:0] z_data_in;
  logic       z_ready_in, z_valid_out, z_empty, z_full;
  logic [7:0] z_data_out;
  logic [0:0] z_count;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  vx_pipe_elastic #(.DATAW(8), .RESETW(2), .DEPTH(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out),
    .count(count), .empty(empty), .full(full)
  );

  vx_pipe_elastic #(.DATAW(8), .RESETW(0), .DEPTH(0)) dut0 (
    .clk(clk), .reset(reset), .flush(z_flush),
    .valid_in(z_valid_in), .data_in(z_data_in), .ready_in(z_ready_in),
    .valid_out(z_valid_out), .data_out(z_data_out), .ready_out(z_ready_out),
    .count(z_count), .empty(z_empty), .full(z_full)
  );

  // Monitor: pop and compare on every output handshake; record accepted inputs.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (reset === 1'b1 && valid_out === 1'b1 && ready_out === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got data_out=%02h, required no output", data_out);
      end else begin
        exp = sb.pop_front();
        if (data_out !== exp) begin
          errors++;
          $display("FAIL sb_data: got %02h, required %02h", data_out, exp);
        end
      end
    end
    if (valid_in === 1'b1 && ready_in === 1'b1) sb.push_back(data_in);
    if (reset !== 1'b1 || flush === 1'b1) sb.delete();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = 8'h00;
    z_valid_in = 1'b0; z_ready_out = 1'b0; z_flush = 1'b0; z_data_in = 8'h00;

    // Reset
    nxt();
    @(negedge clk); chk("rst_ready_in", ready_in, 0);
    nxt(); reset = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0); chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);   chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_after", ready_in, 1);

    // Streaming A,B,C with ready_out=1
    nxt(); ready_out = 1'b1; valid_in = 1'b1; data_in = 8'h11;
    @(negedge clk); chk("t1_rdy0", ready_in, 1);
    nxt(); data_in = 8'h22;
    @(negedge clk); chk("t1_rdy1", ready_in, 1);
    nxt(); data_in = 8'h33;
    @(negedge clk); chk("t1_rdy2", ready_in, 1); chk("t1_lat_vo", valid_out, 0);
    nxt(); valid_in = 1'b0;
    @(negedge clk); chk("t1_count", count, 3); chk("t1_vo", valid_out, 1);
    chk("t1_data", data_out, 8'h11);
    nxt(); nxt(); nxt();
    @(negedge clk); chk("t1_empty", empty, 1);

    // Backpressure: A,B,C fill, D held, then release
    nxt(); ready_out = 1'b0; valid_in = 1'b1; data_in = 8'hA1;
    @(negedge clk); chk("t2_rdy0", ready_in, 1);
    nxt(); data_in = 8'hB2;
    @(negedge clk); chk("t2_rdy1", ready_in, 1);
    nxt(); data_in = 8'hC3;
    @(negedge clk); chk("t2_rdy2", ready_in, 1);
    nxt(); data_in = 8'hD4;
    @(negedge clk); chk("t2_rdy3", ready_in, 0); chk("t2_full", full, 1);
    chk("t2_vo", valid_out, 1);
    nxt();
    @(negedge clk); chk("t2_hold_data", data_out, 8'hA1); chk("t2_rdy4", ready_in, 0);
    nxt(); ready_out = 1'b1;
    @(negedge clk); chk("t2_rdy5", ready_in, 1); chk("t2_full5", full, 1);
    nxt(); valid_in = 1'b0;
    @(negedge clk); chk("t2_count_same", count, 3);
    nxt(); nxt(); nxt();
    @(negedge clk); chk("t2_empty", empty, 1);

    // Bubble collapse with ready_out=0
    nxt(); ready_out = 1'b0; valid_in = 1'b1; data_in = 8'h31;
    @(negedge clk); chk("t3_rdy0", ready_in, 1);
    nxt(); valid_in = 1'b0;
    nxt(); nxt(); valid_in = 1'b1; data_in = 8'h32;
    @(negedge clk); chk("t3_vo", valid_out, 1); chk("t3_count", count, 1);
    chk("t3_rdy", ready_in, 1); chk("t3_data", data_out, 8'h31);
    nxt(); data_in = 8'h33;
    @(negedge clk); chk("t3_rdy2", ready_in, 1);
    nxt(); valid_in = 1'b0;
    @(negedge clk); chk("t3_full", full, 1); chk("t3_rdy_full", ready_in, 0);
    chk("t3_count3", count, 3);

    // Flush while full with ready_out=1
    nxt(); flush = 1'b1; ready_out = 1'b1; valid_in = 1'b1; data_in = 8'hEE;
    @(negedge clk); chk("t4_rdy", ready_in, 0); chk("t4_vo", valid_out, 1);
    nxt(); flush = 1'b0; valid_in = 1'b0;
    @(negedge clk); chk("t4_count", count, 0); chk("t4_vo_after", valid_out, 0);
    chk("t4_empty", empty, 1);

    // Reset mid-stream with stages holding 0xFF
    nxt(); ready_out = 1'b0; valid_in = 1'b1; data_in = 8'hFF;
    nxt(); nxt();
    nxt(); valid_in = 1'b0; reset = 1'b0;
    @(negedge clk); chk("t5_rdy_rst", ready_in, 0); chk("t5_full_pre", full, 1);
    nxt(); reset = 1'b1; valid_in = 1'b1; data_in = 8'h5A; ready_out = 1'b1;
    @(negedge clk);
    chk("t5_vo", valid_out, 0); chk("t5_count", count, 0);
    chk("t5_empty", empty, 1); chk("t5_full", full, 0);
    chk("t5_msb_clr", data_out[7:6], 2'b00); chk("t5_lsb_keep", data_out[5:0], 6'h3F);
    chk("t5_rdy", ready_in, 1);
    nxt(); valid_in = 1'b0;
    nxt();
    @(negedge clk); chk("t5_lat2", valid_out, 0);
    nxt();
    @(negedge clk); chk("t5_lat3", valid_out, 1); chk("t5_data", data_out, 8'h5A);
    nxt(); nxt();
    @(negedge clk); chk("drain_sb", sb.size(), 0); chk("drain_empty", empty, 1);

    // DEPTH=0 passthrough
    for (int k = 0; k < 8; k++) begin
      logic       v, r, f;
      logic [7:0] d;
      v = 1'($urandom); r = 1'($urandom); f = 1'($urandom); d = 8'($urandom);
      z_valid_in = v; z_ready_out = r; z_flush = f; z_data_in = d;
      #2;
      chk("p0_valid", z_valid_out, v); chk("p0_data", z_data_out, d);
      chk("p0_ready", z_ready_in, r);  chk("p0_count", z_count, 0);
      chk("p0_empty", z_empty, 1);     chk("p0_full", z_full, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
